// File: rtl/lift_scan_controller.sv
// SCAN-scheduled lift controller: latches floor calls, sweeps one direction until no calls remain
// ahead, then reverses. Travel time and door dwell are timed by internal counters.
module lift_scan_controller #(
  parameter int unsigned NFLOORS    = 11,
  parameter int unsigned FW         = $clog2(NFLOORS),
  parameter int unsigned TRAVEL_CYC = 8,
  parameter int unsigned DOOR_CYC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] req,
  input  logic               in_door_obstacle,
  input  logic               in_door_open,
  input  logic               in_door_close,
  output logic [2:0]         current_state,
  output logic [FW-1:0]      pfloor,
  output logic [FW-1:0]      nfloor,
  output logic [NFLOORS-1:0] pending,
  output logic               dir,
  output logic               out_up_direction,
  output logic               out_down_direction,
  output logic               out_door_opening,
  output logic               out_door_closing,
  output logic               out_ready
);

  localparam int unsigned TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int unsigned DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] DoorLoad   = DW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] TopFloor   = FW'(NFLOORS - 1);

  typedef enum logic [2:0] {
    StReady     = 3'd0,
    StMoveUp    = 3'd1,
    StMoveDown  = 3'd2,
    StDoorOpen  = 3'd3,
    StDoorClose = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        pfloor_q, pfloor_d;
  logic                 dir_q, dir_d;
  logic [NFLOORS-1:0]   pending_q, pending_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [4:0]           dec_q, dec_d;  // {up, down, opening, closing, ready}

  logic                 above, below;
  logic [FW-1:0]        up_flr, dn_flr;
  logic [NFLOORS-1:0]   pend_any, clr;
  logic                 obst_open;

  function automatic logic beyond(input logic [NFLOORS-1:0] v, input logic [FW-1:0] f,
                                  input logic up);
    beyond = 1'b0;
    for (int i = 0; i < int'(NFLOORS); i++) begin
      if (v[i] && (up ? (i > int'(f)) : (i < int'(f)))) beyond = 1'b1;
    end
  endfunction

  // Nearest pending floor on each side of the cabin.
  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    up_flr = pfloor_q;
    dn_flr = pfloor_q;
    for (int i = int'(NFLOORS) - 1; i >= 0; i--) begin
      if (i > int'(pfloor_q) && pending_q[i]) begin
        above  = 1'b1;
        up_flr = FW'(i);
      end
    end
    for (int i = 0; i < int'(NFLOORS); i++) begin
      if (i < int'(pfloor_q) && pending_q[i]) begin
        below  = 1'b1;
        dn_flr = FW'(i);
      end
    end
    if (dir_q) nfloor = above ? up_flr : (below ? dn_flr : pfloor_q);
    else       nfloor = below ? dn_flr : (above ? up_flr : pfloor_q);
  end

  always_comb begin
    state_d   = state_q;
    pfloor_d  = pfloor_q;
    dir_d     = dir_q;
    tcnt_d    = '0;
    dcnt_d    = dcnt_q;
    pend_any  = pending_q | req;
    obst_open = in_door_obstacle | in_door_open;

    unique case (state_q)
      StReady: begin
        if (in_door_open || pending_q[pfloor_q]) begin
          state_d = StDoorOpen;
          dcnt_d  = DoorLoad;
        end else if (dir_q) begin
          if (above) begin
            state_d = StMoveUp;
          end else if (below) begin
            state_d = StMoveDown;
            dir_d   = 1'b0;
          end
        end else begin
          if (below) begin
            state_d = StMoveDown;
          end else if (above) begin
            state_d = StMoveUp;
            dir_d   = 1'b1;
          end
        end
      end
      StMoveUp, StMoveDown: begin
        if (tcnt_q == TravelLast) begin
          if (state_q == StMoveUp && pfloor_q != TopFloor) pfloor_d = pfloor_q + FW'(1);
          else if (state_q == StMoveDown && pfloor_q != '0) pfloor_d = pfloor_q - FW'(1);
          if (pend_any[pfloor_d]) begin
            state_d = StDoorOpen;
            dcnt_d  = DoorLoad;
          end else if (!beyond(pend_any, pfloor_d, state_q == StMoveUp)) begin
            // Nothing left ahead; let READY reschedule rather than run into the end stop.
            state_d = StReady;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StDoorOpen: begin
        if (obst_open) begin
          dcnt_d = DoorLoad;
        end else if (dcnt_q == '0 || in_door_close) begin
          state_d = StDoorClose;
          dcnt_d  = DoorLoad;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      StDoorClose: begin
        if (obst_open) begin
          state_d = StDoorOpen;
          dcnt_d  = DoorLoad;
        end else if (dcnt_q == '0) begin
          state_d = StReady;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: state_d = StReady;
    endcase

    if (pfloor_d == TopFloor) dir_d = 1'b0;
    else if (pfloor_d == '0)  dir_d = 1'b1;

    // Serving the floor wins over a fresh call for it.
    clr = '0;
    if (state_d == StDoorOpen) clr[pfloor_d] = 1'b1;
    pending_d = pend_any & ~clr;

    unique case (state_d)
      StMoveUp:    dec_d = 5'b10000;
      StMoveDown:  dec_d = 5'b01000;
      StDoorOpen:  dec_d = 5'b00100;
      StDoorClose: dec_d = 5'b00010;
      default:     dec_d = 5'b00001;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReady;
      pfloor_q  <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      dec_q     <= 5'b00001;
    end else begin
      state_q   <= state_d;
      pfloor_q  <= pfloor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      dec_q     <= dec_d;
    end
  end

  assign current_state      = state_q;
  assign pfloor             = pfloor_q;
  assign pending            = pending_q;
  assign dir                = dir_q;
  assign out_up_direction   = dec_q[4];
  assign out_down_direction = dec_q[3];
  assign out_door_opening   = dec_q[2];
  assign out_door_closing   = dec_q[1];
  assign out_ready          = dec_q[0];

endmodule

// File: tb/tb_lift_scan_controller.sv
// Directed bench for lift_scan_controller with NFLOORS=11, TRAVEL_CYC=4, DOOR_CYC=3.
module tb_lift_scan_controller;

  logic        clk;
  logic        rst_n;
  logic [10:0] req;
  logic        in_door_obstacle, in_door_open, in_door_close;
  logic [2:0]  current_state;
  logic [3:0]  pfloor, nfloor;
  logic [10:0] pending;
  logic        dir;
  logic        out_up_direction, out_down_direction, out_door_opening, out_door_closing;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  lift_scan_controller #(
    .NFLOORS   (11),
    .FW        (4),
    .TRAVEL_CYC(4),
    .DOOR_CYC  (3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .in_door_obstacle  (in_door_obstacle),
    .in_door_open      (in_door_open),
    .in_door_close     (in_door_close),
    .current_state     (current_state),
    .pfloor            (pfloor),
    .nfloor            (nfloor),
    .pending           (pending),
    .dir               (dir),
    .out_up_direction  (out_up_direction),
    .out_down_direction(out_down_direction),
    .out_door_opening  (out_door_opening),
    .out_door_closing  (out_door_closing),
    .out_ready         (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st);
    logic [4:0] dec_exp;
    case (st)
      3'd1:    dec_exp = 5'b10000;
      3'd2:    dec_exp = 5'b01000;
      3'd3:    dec_exp = 5'b00100;
      3'd4:    dec_exp = 5'b00010;
      default: dec_exp = 5'b00001;
    endcase
    check({tag, ".state"}, 32'(current_state), 32'(st));
    check({tag, ".dec"}, 32'({out_up_direction, out_down_direction, out_door_opening,
                              out_door_closing, out_ready}), 32'(dec_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    in_door_obstacle = 1'b0;
    in_door_open = 1'b0;
    in_door_close = 1'b0;
    repeat (2) tick();
    chk_state("reset", 3'd0);
    check("reset.pfloor", 32'(pfloor), 32'd0);
    check("reset.pending", 32'(pending), 32'h000);
    check("reset.dir", 32'(dir), 32'd1);
    check("reset.nfloor", 32'(nfloor), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_state("idle", 3'd0);

    // Call to floor 5 from floor 0.
    req = 11'h020;
    tick();
    req = '0;
    check("t1.pending", 32'(pending), 32'h020);
    chk_state("t1.latched", 3'd0);
    tick();
    chk_state("t1.start", 3'd1);
    check("t1.nfloor", 32'(nfloor), 32'd5);
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick();
      check("t1.pfloor", 32'(pfloor), 32'(k));
      if (k < 5) chk_state("t1.moving", 3'd1);
    end
    chk_state("t1.arrive", 3'd3);
    check("t1.cleared", 32'(pending), 32'h000);
    check("t1.dir", 32'(dir), 32'd1);
    repeat (3) tick();
    chk_state("t1.closing", 3'd4);
    repeat (3) tick();
    chk_state("t1.ready", 3'd0);

    // At 5 heading up with calls at 2 and 7: serve 7, then reverse to 2.
    req = 11'h084;
    tick();
    req = '0;
    check("t3.pending", 32'(pending), 32'h084);
    tick();
    chk_state("t3.up", 3'd1);
    check("t3.nfloor", 32'(nfloor), 32'd7);
    repeat (4) tick();
    check("t3.pass6", 32'(pfloor), 32'd6);
    chk_state("t3.pass6", 3'd1);
    repeat (4) tick();
    check("t3.at7", 32'(pfloor), 32'd7);
    chk_state("t3.at7", 3'd3);
    check("t3.pend7", 32'(pending), 32'h004);
    check("t3.next2", 32'(nfloor), 32'd2);
    check("t3.dir7", 32'(dir), 32'd1);
    repeat (6) tick();
    chk_state("t3.ready7", 3'd0);
    tick();
    chk_state("t3.down", 3'd2);
    check("t3.dirflip", 32'(dir), 32'd0);
    repeat (20) tick();
    check("t3.at2", 32'(pfloor), 32'd2);
    chk_state("t3.at2", 3'd3);
    check("t3.pend2", 32'(pending), 32'h000);
    repeat (6) tick();
    chk_state("t3.ready2", 3'd0);

    // Call at the present floor, obstacle hold, reopen and close button.
    req = 11'h004;
    tick();
    req = '0;
    check("t4.pending", 32'(pending), 32'h004);
    chk_state("t4.latched", 3'd0);
    tick();
    chk_state("t4.open", 3'd3);
    check("t4.cleared", 32'(pending), 32'h000);
    in_door_obstacle = 1'b1;
    repeat (5) tick();
    req = 11'h004;
    tick();
    req = '0;
    check("t4.dropreq", 32'(pending), 32'h000);
    repeat (4) tick();
    chk_state("t4.held", 3'd3);
    in_door_obstacle = 1'b0;
    repeat (2) tick();
    chk_state("t4.dwell", 3'd3);
    tick();
    chk_state("t4.close", 3'd4);
    in_door_obstacle = 1'b1;
    tick();
    chk_state("t4.reopen", 3'd3);
    in_door_obstacle = 1'b0;
    in_door_close = 1'b1;
    tick();
    chk_state("t4.closebtn", 3'd4);
    in_door_close = 1'b0;
    repeat (3) tick();
    chk_state("t4.ready", 3'd0);
    check("t4.nomove", 32'(pfloor), 32'd2);

    // Fresh start: run 0->8, intermediate call to 3 picked up on the way.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check("t2.reset", 32'(pfloor), 32'd0);
    req = 11'h100;
    tick();
    req = '0;
    check("t2.pending", 32'(pending), 32'h100);
    tick();
    chk_state("t2.up", 3'd1);
    repeat (4) tick();
    check("t2.at1", 32'(pfloor), 32'd1);
    req = 11'h008;
    tick();
    req = '0;
    check("t2.pend", 32'(pending), 32'h108);
    repeat (7) tick();
    check("t2.at3", 32'(pfloor), 32'd3);
    chk_state("t2.stop3", 3'd3);
    check("t2.clr3", 32'(pending), 32'h100);
    check("t2.next8", 32'(nfloor), 32'd8);
    repeat (6) tick();
    chk_state("t2.ready3", 3'd0);
    tick();
    chk_state("t2.resume", 3'd1);
    repeat (20) tick();
    check("t2.at8", 32'(pfloor), 32'd8);
    chk_state("t2.stop8", 3'd3);
    check("t2.clr8", 32'(pending), 32'h000);
    repeat (6) tick();
    chk_state("t2.ready8", 3'd0);

    // Top floor forces dir down; then reset mid-descent.
    req = 11'h400;
    tick();
    req = '0;
    tick();
    chk_state("t5.up", 3'd1);
    repeat (8) tick();
    check("t5.at10", 32'(pfloor), 32'd10);
    chk_state("t5.stop10", 3'd3);
    check("t5.dirtop", 32'(dir), 32'd0);
    repeat (6) tick();
    chk_state("t5.ready10", 3'd0);
    req = 11'h001;
    tick();
    req = '0;
    tick();
    chk_state("t5.down", 3'd2);
    repeat (16) tick();
    check("t5.at6", 32'(pfloor), 32'd6);
    chk_state("t5.moving6", 3'd2);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("t5.async", 3'd0);
    check("t5.async.pfloor", 32'(pfloor), 32'd0);
    check("t5.async.pending", 32'(pending), 32'h000);
    check("t5.async.dir", 32'(dir), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
